// File: rtl/pc_sequencer.sv
// Program-counter sequencer with NEXT/BRANCH/JUMP/CALL/RET and a return-address stack.
// One-cycle latency; Enable=0 stalls all state; stack overflow/underflow sets a sticky fault.
module pc_sequencer #(
    parameter int                ADDR_W      = 10,
    parameter int                OFS_W       = 6,
    parameter int                STACK_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Enable,
    input  logic [2:0]        iOp,
    input  logic              iCond,
    input  logic [OFS_W-1:0]  iSalto,
    input  logic [ADDR_W-1:0] iTarget,
    output logic [ADDR_W-1:0] oPC,
    output logic              oStackEmpty,
    output logic              oStackFull,
    output logic              oFault
);
    localparam int CNT_W = $clog2(STACK_DEPTH + 1);
    localparam int PTR_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(STACK_DEPTH);

    localparam logic [2:0] OP_BRANCH = 3'd1;
    localparam logic [2:0] OP_JUMP   = 3'd2;
    localparam logic [2:0] OP_CALL   = 3'd3;
    localparam logic [2:0] OP_RET    = 3'd4;

    logic [ADDR_W-1:0] stack [STACK_DEPTH];
    logic [CNT_W-1:0]  count, count_nxt;
    logic [ADDR_W-1:0] seq, ofs_ext, pc_nxt, top;
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic              push, fault_set;

    assign seq     = oPC + ADDR_W'(1);
    assign ofs_ext = ADDR_W'($signed(iSalto));
    assign wr_ptr  = PTR_W'(count);
    assign rd_ptr  = PTR_W'(count - CNT_W'(1));
    assign top     = stack[rd_ptr];

    always_comb begin
        pc_nxt    = seq;
        count_nxt = count;
        push      = 1'b0;
        fault_set = 1'b0;
        case (iOp)
            OP_BRANCH: if (iCond) pc_nxt = seq + ofs_ext;
            OP_JUMP:   pc_nxt = iTarget;
            OP_CALL: begin
                if (count == CNT_FULL) begin
                    pc_nxt    = oPC;
                    fault_set = 1'b1;
                end else begin
                    push      = 1'b1;
                    count_nxt = count + CNT_W'(1);
                    pc_nxt    = iTarget;
                end
            end
            OP_RET: begin
                if (count == '0) begin
                    pc_nxt    = oPC;
                    fault_set = 1'b1;
                end else begin
                    pc_nxt    = top;
                    count_nxt = count - CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    // Flags are registered from count_nxt so they change on the same edge as count.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            oPC         <= RESET_PC;
            count       <= '0;
            oStackEmpty <= 1'b1;
            oStackFull  <= 1'b0;
            oFault      <= 1'b0;
        end else if (Enable) begin
            oPC         <= pc_nxt;
            count       <= count_nxt;
            oStackEmpty <= (count_nxt == '0);
            oStackFull  <= (count_nxt == CNT_FULL);
            oFault      <= oFault | fault_set;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset && Enable && push) stack[wr_ptr] <= seq;
    end
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer at default parameters.
module tb_pc_sequencer;
    logic       Clock = 1'b0;
    logic       Reset = 1'b0;
    logic       Enable = 1'b0;
    logic [2:0] iOp = 3'd0;
    logic       iCond = 1'b0;
    logic [5:0] iSalto = 6'd0;
    logic [9:0] iTarget = 10'd0;
    logic [9:0] oPC;
    logic       oStackEmpty, oStackFull, oFault;

    int checks = 0;
    int errors = 0;

    localparam logic [2:0] NEXT = 3'd0, BRANCH = 3'd1, JUMP = 3'd2, CALL = 3'd3, RET = 3'd4;

    pc_sequencer dut (
        .Clock(Clock), .Reset(Reset), .Enable(Enable), .iOp(iOp), .iCond(iCond),
        .iSalto(iSalto), .iTarget(iTarget), .oPC(oPC), .oStackEmpty(oStackEmpty),
        .oStackFull(oStackFull), .oFault(oFault)
    );

    always #5 Clock = ~Clock;

    task automatic step(input logic [2:0] op, input logic c, input logic [5:0] s,
                        input logic [9:0] t, input logic en);
        iOp = op; iCond = c; iSalto = s; iTarget = t; Enable = en;
        @(posedge Clock);
        #1;
    endtask

    task automatic test_reset;
        Reset = 1'b0; Enable = 1'b1; iOp = NEXT;
        repeat (2) @(posedge Clock);
        #1;
        checks++; if (oPC !== 10'd0) begin errors++; $display("FAIL reset_pc got %0d want 0", oPC); end
        checks++; if (oStackEmpty !== 1'b1 || oStackFull !== 1'b0 || oFault !== 1'b0) begin
            errors++; $display("FAIL reset_flags got e%b f%b x%b want e1 f0 x0", oStackEmpty, oStackFull, oFault); end
        Reset = 1'b1;
    endtask

    task automatic test_next;
        for (int i = 1; i <= 3; i++) begin
            step(NEXT, 1'b0, 6'd0, 10'd0, 1'b1);
            checks++; if (oPC !== 10'(i)) begin errors++; $display("FAIL next%0d got %0d want %0d", i, oPC, i); end
        end
        checks++; if (oStackEmpty !== 1'b1 || oFault !== 1'b0) begin
            errors++; $display("FAIL next_flags got e%b x%b want e1 x0", oStackEmpty, oFault); end
    endtask

    task automatic test_branch;
        step(JUMP, 1'b0, 6'd0, 10'd7, 1'b1);
        checks++; if (oPC !== 10'd7) begin errors++; $display("FAIL jump7 got %0d want 7", oPC); end
        step(BRANCH, 1'b1, 6'b000111, 10'd0, 1'b1);
        checks++; if (oPC !== 10'd15) begin errors++; $display("FAIL br_fwd got %0d want 15", oPC); end
        step(BRANCH, 1'b1, 6'b111000, 10'd0, 1'b1);
        checks++; if (oPC !== 10'd8) begin errors++; $display("FAIL br_back got %0d want 8", oPC); end
        step(BRANCH, 1'b0, 6'b111000, 10'd0, 1'b1);
        checks++; if (oPC !== 10'd9) begin errors++; $display("FAIL br_not_taken got %0d want 9", oPC); end
    endtask

    task automatic test_wrap;
        step(JUMP, 1'b0, 6'd0, 10'd1023, 1'b1);
        step(NEXT, 1'b0, 6'd0, 10'd0, 1'b1);
        checks++; if (oPC !== 10'd0) begin errors++; $display("FAIL wrap_next got %0d want 0", oPC); end
        step(JUMP, 1'b0, 6'd0, 10'd1020, 1'b1);
        step(BRANCH, 1'b1, 6'd7, 10'd0, 1'b1);
        checks++; if (oPC !== 10'd4) begin errors++; $display("FAIL wrap_br got %0d want 4", oPC); end
        step(3'd5, 1'b1, 6'd7, 10'd900, 1'b1);
        checks++; if (oPC !== 10'd5) begin errors++; $display("FAIL op5 got %0d want 5", oPC); end
        step(3'd7, 1'b1, 6'd7, 10'd900, 1'b1);
        checks++; if (oPC !== 10'd6) begin errors++; $display("FAIL op7 got %0d want 6", oPC); end
    endtask

    task automatic test_call_ret;
        logic [9:0] tgt [4] = '{10'd100, 10'd200, 10'd300, 10'd400};
        logic [9:0] ret [4] = '{10'd301, 10'd201, 10'd101, 10'd6};
        step(JUMP, 1'b0, 6'd0, 10'd5, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step(CALL, 1'b0, 6'd0, tgt[i], 1'b1);
            checks++; if (oPC !== tgt[i] || oStackFull !== (i == 3) || oStackEmpty !== 1'b0) begin
                errors++; $display("FAIL call%0d got pc %0d full %b empty %b want pc %0d full %b empty 0",
                                   i, oPC, oStackFull, oStackEmpty, tgt[i], (i == 3)); end
        end
        step(CALL, 1'b0, 6'd0, 10'd500, 1'b1);
        checks++; if (oPC !== 10'd400 || oFault !== 1'b1 || oStackFull !== 1'b1) begin
            errors++; $display("FAIL overflow got pc %0d fault %b full %b want 400 1 1", oPC, oFault, oStackFull); end
        for (int i = 0; i < 4; i++) begin
            step(RET, 1'b0, 6'd0, 10'd0, 1'b1);
            checks++; if (oPC !== ret[i] || oStackEmpty !== (i == 3) || oStackFull !== 1'b0) begin
                errors++; $display("FAIL ret%0d got pc %0d empty %b full %b want pc %0d empty %b full 0",
                                   i, oPC, oStackEmpty, oStackFull, ret[i], (i == 3)); end
        end
        step(RET, 1'b0, 6'd0, 10'd0, 1'b1);
        checks++; if (oPC !== 10'd6 || oFault !== 1'b1) begin
            errors++; $display("FAIL underflow got pc %0d fault %b want 6 1", oPC, oFault); end
    endtask

    task automatic test_stall_reset;
        Reset = 1'b0; #2; Reset = 1'b1;
        step(NEXT, 1'b0, 6'd0, 10'd0, 1'b1);
        step(CALL, 1'b0, 6'd0, 10'd50, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(CALL, 1'b0, 6'd0, 10'd100, 1'b0);
            checks++; if (oPC !== 10'd50 || oStackEmpty !== 1'b0 || oStackFull !== 1'b0 || oFault !== 1'b0) begin
                errors++; $display("FAIL stall%0d got pc %0d e%b f%b x%b want 50 e0 f0 x0",
                                   i, oPC, oStackEmpty, oStackFull, oFault); end
        end
        step(CALL, 1'b0, 6'd0, 10'd100, 1'b1);
        checks++; if (oPC !== 10'd100) begin errors++; $display("FAIL post_stall got %0d want 100", oPC); end
        #3; Reset = 1'b0; #1;
        checks++; if (oPC !== 10'd0 || oStackEmpty !== 1'b1 || oFault !== 1'b0) begin
            errors++; $display("FAIL async_reset got pc %0d e%b x%b want 0 e1 x0", oPC, oStackEmpty, oFault); end
        @(posedge Clock); #1; Reset = 1'b1;
        step(RET, 1'b0, 6'd0, 10'd0, 1'b1);
        checks++; if (oPC !== 10'd0 || oFault !== 1'b1 || oStackEmpty !== 1'b1) begin
            errors++; $display("FAIL ret_after_reset got pc %0d x%b e%b want 0 x1 e1", oPC, oFault, oStackEmpty); end
    endtask

    task automatic test_back_to_back;
        logic [2:0] ops [7] = '{CALL, RET, CALL, CALL, RET, CALL, RET};
        logic [9:0] tg  [7] = '{10'd40, 10'd0, 10'd10, 10'd20, 10'd0, 10'd30, 10'd0};
        logic [9:0] exp [7] = '{10'd40, 10'd1, 10'd10, 10'd20, 10'd11, 10'd30, 10'd12};
        for (int i = 0; i < 7; i++) begin
            step(ops[i], 1'b0, 6'd0, tg[i], 1'b1);
            checks++; if (oPC !== exp[i]) begin
                errors++; $display("FAIL b2b%0d got %0d want %0d", i, oPC, exp[i]); end
        end
        step(RET, 1'b0, 6'd0, 10'd0, 1'b1);
        checks++; if (oPC !== 10'd2 || oStackEmpty !== 1'b1 || oFault !== 1'b1) begin
            errors++; $display("FAIL b2b_last got pc %0d e%b x%b want 2 e1 x1", oPC, oStackEmpty, oFault); end
    endtask

    initial begin
        test_reset();
        test_next();
        test_branch();
        test_wrap();
        test_call_ret();
        test_stall_reset();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 10: program-counter width in bits.
REQ-002 The block SHALL have parameter OFS_W, default 6: signed branch-offset width in bits.
REQ-003 The block SHALL have parameter STACK_DEPTH, default 4: return-address stack entries (>=1).
REQ-004 The block SHALL have parameter RESET_PC, default 0: oPC value after reset.
REQ-005 The block SHALL have port Clock, input, 1 bit: single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port Reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port Enable, input, 1 bit: 1 advances the sequencer; 0 stalls (all state held).
REQ-008 The block SHALL have port iOp, input, 3 bits: 0 NEXT, 1 BRANCH, 2 JUMP, 3 CALL, 4 RET; 5-7 treated as NEXT.
REQ-009 The block SHALL have port iCond, input, 1 bit: branch-taken condition, used only by BRANCH.
REQ-010 The block SHALL have port iSalto, input, OFS_W bits: two's-complement branch offset.
REQ-011 The block SHALL have port iTarget, input, ADDR_W bits: absolute destination for JUMP and CALL.
REQ-012 The block SHALL have port oPC, output, ADDR_W bits: current program counter, registered.
REQ-013 The block SHALL have port oStackEmpty, output, 1 bit: stack count == 0, registered.
REQ-014 The block SHALL have port oStackFull, output, 1 bit: stack count == STACK_DEPTH, registered.
REQ-015 The block SHALL have port oFault, output, 1 bit: sticky flag for stack overflow/underflow, registered.

Function
REQ-016 The block SHALL update oPC, stack, count and oFault only on a rising Clock edge with Enable=1 and Reset=1.
REQ-017 The block SHALL define seq = oPC+1, truncated to ADDR_W bits (1023 -> 0 at ADDR_W=10).
REQ-018 On NEXT, the block SHALL load oPC <= seq.
REQ-019 On BRANCH with iCond=1, the block SHALL load oPC <= seq + sign-extended iSalto, modulo 2^ADDR_W.
REQ-020 On BRANCH with iCond=0, the block SHALL load oPC <= seq.
REQ-021 On JUMP, the block SHALL load oPC <= iTarget; stack unchanged.
REQ-022 On CALL with count < STACK_DEPTH, the block SHALL push seq, increment count, and load oPC <= iTarget.
REQ-023 On CALL with count == STACK_DEPTH, the block SHALL leave oPC and stack unchanged and set oFault.
REQ-024 On RET with count > 0, the block SHALL load oPC <= top entry and decrement count.
REQ-025 On RET with count == 0, the block SHALL leave oPC unchanged and set oFault.
REQ-026 The stack SHALL be strictly LIFO; one push or one pop at most per cycle; entries beyond count are don't-care.
REQ-027 oStackEmpty/oStackFull SHALL reflect the count after the same edge that changes it (zero-cycle flag lag relative to count).
REQ-028 oFault SHALL stay 1 once set until Reset; it SHALL NOT block further operations.
REQ-029 Latency SHALL be one cycle: an operation presented before edge N is visible on oPC after edge N.

Reset
REQ-030 While Reset=0, the block SHALL asynchronously force oPC=RESET_PC, count=0, oStackEmpty=1, oStackFull=0, oFault=0.
REQ-031 Reset asserted mid-operation SHALL discard all stack contents; the first enabled edge after release SHALL execute the presented iOp from RESET_PC.

Verification (ADDR_W=10, OFS_W=6, STACK_DEPTH=4, RESET_PC=0)
REQ-032 Reset=0 then released, Enable=1, NEXT x3 -> oPC 0,1,2,3; oStackEmpty=1, oFault=0.
REQ-033 From oPC=7: BRANCH iCond=1 iSalto=6'b000111 -> 15; then iSalto=6'b111000 (-8) -> 8; then iCond=0 -> 9.
REQ-034 Wrap: oPC=1023 NEXT -> 0; oPC=1020 BRANCH iCond=1 iSalto=+7 -> 4.
REQ-035 From oPC=5: CALL to 100,200,300,400 -> oStackFull=1; 5th CALL to 500 -> oPC=400, oFault=1; RET x4 -> 301,201,101,6, oStackEmpty=1; extra RET -> oPC=6.
REQ-036 Enable=0 with CALL to 100 held 3 cycles -> oPC, count and flags unchanged; Reset pulsed with 2 entries stacked -> oPC=0, oStackEmpty=1, oFault=0; next RET -> oFault=1.
